mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 87 ++++++++
 rtl/mc_decode.sv | 56 +++++
 rtl/mc_controller.sv | 167 ++++++++++++++++
 tb/tb_mc_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes, opcode/func
// constants and the datapath select encodings driven by the controller.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_WB     = 4'd3,
        S_BR     = 4'd4,
        S_MADR   = 4'd5,
        S_MEM    = 4'd6,
        S_MWB    = 4'd7
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_OR   = 3'd2,
        ALU_SRL  = 3'd3,
        ALU_SLL  = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_AND  = 3'd6,
        ALU_SRAV = 3'd7
    } alu_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_GPR    = 2'd3
    } pcsrc_e;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } regdst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } memtoreg_e;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_LUI  = 2'd1,
        EXT_SIGN = 2'd2
    } extop_e;

    typedef enum logic [3:0] {
        CL_NOP   = 4'd0,
        CL_ALU_R = 4'd1,
        CL_ALU_I = 4'd2,
        CL_BEQ   = 4'd3,
        CL_LW    = 4'd4,
        CL_SW    = 4'd5,
        CL_J     = 4'd6,
        CL_JAL   = 4'd7,
        CL_JR    = 4'd8,
        CL_ILL   = 4'd9
    } cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func classifier feeding the controller FSM.
// Zero latency; no flow control.
module mc_decode
    import mc_controller_pkg::*;
(
    input  logic [31:0] instr,
    output cls_e        cls,
    output alu_e        alu_ctrl,
    output extop_e      ext_op,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] func;

    assign op   = instr[31:26];
    assign func = instr[5:0];

    always_comb begin
        cls      = CL_ILL;
        alu_ctrl = ALU_ADD;
        ext_op   = EXT_ZERO;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD, FN_ADDU: cls = CL_ALU_R;
                    FN_SUBU: begin cls = CL_ALU_R; alu_ctrl = ALU_SUB;  end
                    FN_OR:   begin cls = CL_ALU_R; alu_ctrl = ALU_OR;   end
                    FN_AND:  begin cls = CL_ALU_R; alu_ctrl = ALU_AND;  end
                    FN_XOR:  begin cls = CL_ALU_R; alu_ctrl = ALU_XOR;  end
                    FN_SRL:  begin cls = CL_ALU_R; alu_ctrl = ALU_SRL;  end
                    FN_SRAV: begin cls = CL_ALU_R; alu_ctrl = ALU_SRAV; end
                    // The all-zero word is sll $0,$0,0; treat it as a pure nop.
                    FN_SLL: begin
                        cls      = (instr == 32'd0) ? CL_NOP : CL_ALU_R;
                        alu_ctrl = ALU_SLL;
                    end
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_ILL;
                endcase
            end
            OP_ORI:            begin cls = CL_ALU_I; alu_ctrl = ALU_OR; ext_op = EXT_ZERO; end
            OP_LUI:            begin cls = CL_ALU_I; alu_ctrl = ALU_ADD; ext_op = EXT_LUI; end
            OP_ADDI, OP_ADDIU: begin cls = CL_ALU_I; alu_ctrl = ALU_ADD; ext_op = EXT_SIGN; end
            OP_BEQ:            begin cls = CL_BEQ; alu_ctrl = ALU_SUB; end
            OP_LW:             cls = CL_LW;
            OP_SW:             cls = CL_SW;
            OP_J:              cls = CL_J;
            OP_JAL:            cls = CL_JAL;
            default:           cls = CL_ILL;
        endcase
    end

    assign illegal = (cls == CL_ILL);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// 2-5 cycles per instruction plus memory wait; imem/dmem requests held until rdy.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr,
    input  logic                zero,
    input  logic                imem_rdy,
    input  logic                dmem_rdy,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                IRWr,
    output logic                PCWr,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                ALUSrc,
    output logic [1:0]          PCsrc,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          EXTOp,
    output logic [2:0]          ALUctrl,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire;

    cls_e   dec_cls;
    alu_e   dec_alu;
    extop_e dec_ext;
    logic   dec_illegal;

    mc_decode u_decode (
        .instr    (instr),
        .cls      (dec_cls),
        .alu_ctrl (dec_alu),
        .ext_op   (dec_ext),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        PCsrc    = PC_PLUS4;
        RegDst   = DST_RT;
        MemtoReg = WB_ALU;
        EXTOp    = EXT_ZERO;
        ALUctrl  = ALU_ADD;
        illegal  = 1'b0;
        // Outputs are gated by reset itself so requests drop without waiting for a clock.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_rdy) begin
                        IRWr    = 1'b1;
                        PCWr    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        case (dec_cls)
                            CL_ALU_R, CL_ALU_I: state_d = S_EXE;
                            CL_BEQ:             state_d = S_BR;
                            CL_LW, CL_SW:       state_d = S_MADR;
                            CL_J: begin
                                PCWr = 1'b1; PCsrc = PC_JUMP;
                                state_d = S_FETCH; retire = 1'b1;
                            end
                            CL_JAL: begin
                                PCWr = 1'b1; PCsrc = PC_JUMP;
                                RegWrite = 1'b1; RegDst = DST_RA; MemtoReg = WB_PC4;
                                state_d = S_FETCH; retire = 1'b1;
                            end
                            CL_JR: begin
                                PCWr = 1'b1; PCsrc = PC_GPR;
                                state_d = S_FETCH; retire = 1'b1;
                            end
                            default: begin
                                state_d = S_FETCH; retire = 1'b1;
                            end
                        endcase
                    end
                end
                S_EXE, S_WB: begin
                    ALUSrc  = (dec_cls == CL_ALU_I);
                    EXTOp   = dec_ext;
                    ALUctrl = dec_alu;
                    if (state_q == S_EXE) begin
                        state_d = S_WB;
                    end else begin
                        RegWrite = 1'b1;
                        RegDst   = (dec_cls == CL_ALU_R) ? DST_RD : DST_RT;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end
                end
                S_BR: begin
                    ALUctrl = ALU_SUB;
                    if (zero) begin
                        PCWr  = 1'b1;
                        PCsrc = PC_BRANCH;
                    end
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_MADR: begin
                    ALUSrc  = 1'b1;
                    EXTOp   = EXT_SIGN;
                    state_d = S_MEM;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    MemWrite = (dec_cls == CL_SW);
                    if (dmem_rdy) begin
                        if (dec_cls == CL_LW) begin
                            state_d = S_MWB;
                        end else begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    end
                end
                S_MWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = WB_MEM;
                    state_d  = S_FETCH;
                    retire   = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected state/outputs/retired count
// are queued with the stimulus and compared as each cycle is driven.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero, imem_rdy, dmem_rdy;
    logic        imem_req, dmem_req, IRWr, PCWr, RegWrite, MemWrite, ALUSrc;
    logic [1:0]  PCsrc, RegDst, MemtoReg, EXTOp;
    logic [2:0]  ALUctrl;
    logic [3:0]  state;
    logic        illegal;
    logic [3:0]  retired;

    mc_controller #(.RETIRE_W(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .PCsrc(PCsrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .EXTOp(EXTOp),
        .ALUctrl(ALUctrl), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [18:0] act_sig;
    assign act_sig = {imem_req, dmem_req, IRWr, PCWr, RegWrite, MemWrite, ALUSrc,
                      PCsrc, RegDst, MemtoReg, EXTOp, ALUctrl, illegal};

    localparam logic [18:0] FETCH_HIT  = {7'b1011000, 12'd0};
    localparam logic [18:0] FETCH_WAIT = {7'b1000000, 12'd0};
    localparam logic [18:0] QUIET      = 19'd0;

    typedef struct {
        logic [31:0] instr;
        logic        ir, dr, z;
        logic [3:0]  st;
        logic [18:0] sg;
        logic [3:0]  ret;
        string       nm;
    } exp_t;

    typedef struct {
        logic [31:0] i;
        logic        r;
        logic [1:0]  ex;
        logic [2:0]  al;
        string       nm;
    } alu_case_t;

    exp_t       sb[$];
    logic [3:0] exp_ret;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic logic [18:0] v(input logic im, dm, irw, pcw, rw, mw, as,
                                      input logic [1:0] pcs, rd, mr, ex,
                                      input logic [2:0] al, input logic il);
        return {im, dm, irw, pcw, rw, mw, as, pcs, rd, mr, ex, al, il};
    endfunction

    task automatic push(input logic [31:0] iv, input logic ir, dr, z,
                        input logic [3:0] st, input logic [18:0] sg, input string nm);
        exp_t e;
        e.instr = iv; e.ir = ir; e.dr = dr; e.z = z;
        e.st = st; e.sg = sg; e.ret = exp_ret; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_rdy = 1'b1; dmem_rdy = 1'b1; zero = 1'b0; instr = 32'd0;
        exp_ret = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_tests++;
        if (act_sig !== QUIET) begin n_fail++; $display("FAIL reset_outputs: got %05h want %05h", act_sig, QUIET); end
        n_tests++;
        if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
        @(negedge clk);
        reset = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || act_sig !== FETCH_WAIT) begin
            n_fail++;
            $display("FAIL post_reset_fetch: state=%0d sig=%05h want state=0 sig=%05h", state, act_sig, FETCH_WAIT);
        end
    endtask

    task automatic test_alu();
        alu_case_t tbl[$];
        exp_t e;
        tbl.push_back('{32'h00221821, 1'b1, 2'd0, 3'd0, "addu"});
        tbl.push_back('{32'h00221823, 1'b1, 2'd0, 3'd1, "subu"});
        tbl.push_back('{32'h00021080, 1'b1, 2'd0, 3'd4, "sll"});
        tbl.push_back('{32'h00021082, 1'b1, 2'd0, 3'd3, "srl"});
        tbl.push_back('{32'h00221807, 1'b1, 2'd0, 3'd7, "srav"});
        tbl.push_back('{32'h00221824, 1'b1, 2'd0, 3'd6, "and"});
        tbl.push_back('{32'h00221826, 1'b1, 2'd0, 3'd5, "xor"});
        tbl.push_back('{32'h00221825, 1'b1, 2'd0, 3'd2, "or"});
        tbl.push_back('{32'h34220005, 1'b0, 2'd0, 3'd2, "ori"});
        tbl.push_back('{32'h20220005, 1'b0, 2'd2, 3'd0, "addi"});
        tbl.push_back('{32'h24220005, 1'b0, 2'd2, 3'd0, "addiu"});
        foreach (tbl[k]) begin
            push(tbl[k].i, 1, 0, 0, 4'd0, FETCH_HIT, {tbl[k].nm, "/fetch"});
            push(tbl[k].i, 0, 0, 0, 4'd1, QUIET, {tbl[k].nm, "/decode"});
            push(tbl[k].i, 0, 0, 0, 4'd2,
                 v(0,0,0,0,0,0,!tbl[k].r, 2'd0, 2'd0, 2'd0, tbl[k].ex, tbl[k].al, 0), {tbl[k].nm, "/exe"});
            push(tbl[k].i, 0, 0, 0, 4'd3,
                 v(0,0,0,0,1,0,!tbl[k].r, 2'd0, {1'b0, tbl[k].r}, 2'd0, tbl[k].ex, tbl[k].al, 0), {tbl[k].nm, "/wb"});
            exp_ret++;
            push(tbl[k].i, 0, 0, 0, 4'd0, FETCH_WAIT, {tbl[k].nm, "/done"});
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
    endtask

    task automatic test_mem();
        exp_t e;
        // lw with three wait cycles: dmem_req held four cycles, eight cycles in total
        push(32'h8C220004, 1, 0, 0, 4'd0, FETCH_HIT, "lw/fetch");
        push(32'h8C220004, 0, 0, 0, 4'd1, QUIET, "lw/decode");
        push(32'h8C220004, 0, 0, 0, 4'd5, v(0,0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd2,3'd0,0), "lw/madr");
        for (int k = 0; k < 3; k++)
            push(32'h8C220004, 0, 0, 0, 4'd6, v(0,1,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0), "lw/mem_wait");
        push(32'h8C220004, 0, 1, 0, 4'd6, v(0,1,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0), "lw/mem_rdy");
        push(32'h8C220004, 0, 0, 0, 4'd7, v(0,0,0,0,1,0,0,2'd0,2'd0,2'd1,2'd0,3'd0,0), "lw/mwb");
        exp_ret++;
        push(32'h8C220004, 0, 0, 0, 4'd0, FETCH_WAIT, "lw/done");
        // sw with stray rdy strobes in states that did not request them
        push(32'hAC220004, 1, 1, 0, 4'd0, FETCH_HIT, "sw/fetch");
        push(32'hAC220004, 1, 1, 0, 4'd1, QUIET, "sw/decode_stray_rdy");
        push(32'hAC220004, 1, 1, 0, 4'd5, v(0,0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd2,3'd0,0), "sw/madr_stray_rdy");
        push(32'hAC220004, 0, 1, 0, 4'd6, v(0,1,0,0,0,1,0,2'd0,2'd0,2'd0,2'd0,3'd0,0), "sw/mem_rdy");
        exp_ret++;
        push(32'hAC220004, 0, 0, 0, 4'd0, FETCH_WAIT, "sw/done");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
    endtask

    task automatic test_control();
        exp_t e;
        push(32'h10220003, 1, 0, 1, 4'd0, FETCH_HIT, "beq_t/fetch");
        push(32'h10220003, 0, 0, 1, 4'd1, QUIET, "beq_t/decode");
        push(32'h10220003, 0, 0, 1, 4'd4, v(0,0,0,1,0,0,0,2'd1,2'd0,2'd0,2'd0,3'd1,0), "beq_t/br");
        exp_ret++;
        push(32'h10220003, 0, 0, 0, 4'd0, FETCH_WAIT, "beq_t/done");
        push(32'h10220003, 1, 0, 0, 4'd0, FETCH_HIT, "beq_nt/fetch");
        push(32'h10220003, 0, 0, 0, 4'd1, QUIET, "beq_nt/decode");
        push(32'h10220003, 0, 0, 0, 4'd4, v(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd1,0), "beq_nt/br");
        exp_ret++;
        push(32'h10220003, 0, 0, 0, 4'd0, FETCH_WAIT, "beq_nt/done");
        push(32'h0C000010, 1, 0, 0, 4'd0, FETCH_HIT, "jal/fetch");
        push(32'h0C000010, 0, 0, 0, 4'd1, v(0,0,0,1,1,0,0,2'd2,2'd2,2'd2,2'd0,3'd0,0), "jal/decode");
        exp_ret++;
        push(32'h0C000010, 0, 0, 0, 4'd0, FETCH_WAIT, "jal/done");
        push(32'h08000010, 1, 0, 0, 4'd0, FETCH_HIT, "j/fetch");
        push(32'h08000010, 0, 0, 0, 4'd1, v(0,0,0,1,0,0,0,2'd2,2'd0,2'd0,2'd0,3'd0,0), "j/decode");
        exp_ret++;
        push(32'h08000010, 0, 0, 0, 4'd0, FETCH_WAIT, "j/done");
        push(32'h03E00008, 1, 0, 0, 4'd0, FETCH_HIT, "jr/fetch");
        push(32'h03E00008, 0, 0, 0, 4'd1, v(0,0,0,1,0,0,0,2'd3,2'd0,2'd0,2'd0,3'd0,0), "jr/decode");
        exp_ret++;
        push(32'h03E00008, 0, 0, 0, 4'd0, FETCH_WAIT, "jr/done");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        push(32'hFC000000, 1, 0, 0, 4'd0, FETCH_HIT, "ill_op/fetch");
        push(32'hFC000000, 0, 0, 0, 4'd1, v(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,1), "ill_op/decode");
        push(32'hFC000000, 0, 0, 0, 4'd0, FETCH_WAIT, "ill_op/done");
        push(32'h00000001, 1, 0, 0, 4'd0, FETCH_HIT, "ill_func/fetch");
        push(32'h00000001, 0, 0, 0, 4'd1, v(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,1), "ill_func/decode");
        push(32'h00000001, 0, 0, 0, 4'd0, FETCH_WAIT, "ill_func/done");
        push(32'h00000000, 1, 0, 0, 4'd0, FETCH_HIT, "nop/fetch");
        push(32'h00000000, 0, 0, 0, 4'd1, QUIET, "nop/decode");
        exp_ret++;
        push(32'h00000000, 0, 0, 0, 4'd0, FETCH_WAIT, "nop/done");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] prog[4];
        logic [2:0]  alu[4];
        logic        isr[4];
        prog = '{32'h00221821, 32'h00221826, 32'h34220005, 32'h00021080};
        alu  = '{3'd0, 3'd5, 3'd2, 3'd4};
        isr  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            push(prog[k], 1, 0, 0, 4'd0, FETCH_HIT, "b2b/fetch");
            push(prog[k], 0, 0, 0, 4'd1, QUIET, "b2b/decode");
            push(prog[k], 0, 0, 0, 4'd2, v(0,0,0,0,0,0,!isr[k],2'd0,2'd0,2'd0,2'd0,alu[k],0), "b2b/exe");
            push(prog[k], 0, 0, 0, 4'd3, v(0,0,0,0,1,0,!isr[k],2'd0,{1'b0, isr[k]},2'd0,2'd0,alu[k],0), "b2b/wb");
            exp_ret++;
        end
        push(32'h0, 0, 0, 0, 4'd0, FETCH_WAIT, "b2b/done");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        exp_t e;
        push(32'hAC220004, 1, 0, 0, 4'd0, FETCH_HIT, "rst_sw/fetch");
        push(32'hAC220004, 0, 0, 0, 4'd1, QUIET, "rst_sw/decode");
        push(32'hAC220004, 0, 0, 0, 4'd5, v(0,0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd2,3'd0,0), "rst_sw/madr");
        push(32'hAC220004, 0, 0, 0, 4'd6, v(0,1,0,0,0,1,0,2'd0,2'd0,2'd0,2'd0,3'd0,0), "rst_sw/mem_wait");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (dmem_req !== 1'b0 || MemWrite !== 1'b0 || state !== 4'd0 || retired !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_sw/async_drop: dmem_req=%b MemWrite=%b state=%0d retired=%0d want 0 0 0 0",
                     dmem_req, MemWrite, state, retired);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 4'd0;
        push(32'h00000000, 0, 1, 0, 4'd0, FETCH_WAIT, "rst_sw/after_1");
        push(32'h00000000, 0, 1, 0, 4'd0, FETCH_WAIT, "rst_sw/after_2");
        push(32'h00000000, 1, 0, 0, 4'd0, FETCH_HIT, "rst_sw/nop_fetch");
        push(32'h00000000, 0, 0, 0, 4'd1, QUIET, "rst_sw/nop_decode");
        exp_ret++;
        push(32'h00000000, 0, 0, 0, 4'd0, FETCH_WAIT, "rst_sw/nop_done");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            instr = e.instr; imem_rdy = e.ir; dmem_rdy = e.dr; zero = e.z;
            #1;
            n_tests++;
            if (state !== e.st || act_sig !== e.sg || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: state=%0d sig=%05h retired=%0d, want state=%0d sig=%05h retired=%0d",
                         e.nm, state, act_sig, retired, e.st, e.sg, e.ret);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_control();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
